// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath: run/memory/IR status in, strobes out.
// master = sequencer side, slave = datapath (or bench) side.
interface control_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             mem_ready;
    logic [31:0]      ir;
    logic             PCout;
    logic             Zlowout;
    logic             Zhighout;
    logic             MDRout;
    logic             MARin;
    logic             Zin;
    logic             PCin;
    logic             MDRin;
    logic             IRin;
    logic             Yin;
    logic             HIin;
    logic             LOin;
    logic             Read;
    logic [4:0]       OpCode;
    logic [15:0]      R_out;
    logic [15:0]      R_in;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, mem_ready, ir,
        output PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin,
               Yin, HIin, LOin, Read, OpCode, R_out, R_in, halted, instr_count
    );

    modport slave (
        output run, mem_ready, ir,
        input  PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin,
               Yin, HIin, LOin, Read, OpCode, R_out, R_in, halted, instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// Moore control FSM for the datapath: fetch (stalls in T1W on mem_ready), decode, execute, retire.
// ALU 6 cycles, mul/div 7, no-op 4 from T0 entry; run is honoured only in IDLE and at retire.
module control_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               clr,
    control_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    localparam logic [4:0] OP_INC  = 5'd12;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_HALT = 5'd27;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic             retire;

    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       is_alu;
    logic       is_md;
    logic       ir_unused;

    assign op        = bus.ir[31:27];
    assign ra        = bus.ir[26:23];
    assign rb        = bus.ir[22:19];
    assign rc        = bus.ir[18:15];
    assign ir_unused = ^bus.ir[14:0];
    assign is_alu    = (op <= 5'd11);
    assign is_md     = (op == OP_MUL) || (op == OP_DIV);

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (retire) count <= count + CNT_W'(1);
        end
    end

    assign bus.instr_count = count;

    always_comb begin
        state_nxt    = state;
        retire       = 1'b0;
        bus.PCout    = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.MDRout   = 1'b0;
        bus.MARin    = 1'b0;
        bus.Zin      = 1'b0;
        bus.PCin     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.Read     = 1'b0;
        bus.OpCode   = '0;
        bus.R_out    = '0;
        bus.R_in     = '0;
        bus.halted   = (state == S_HALT);

        case (state)
            S_IDLE: if (bus.run) state_nxt = S_T0;
            S_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.Zin    = 1'b1;
                bus.OpCode = OP_INC;
                state_nxt  = S_T1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                state_nxt   = bus.mem_ready ? S_T2 : S_T1W;
            end
            // PC already advanced in T1; only keep the read open here
            S_T1W: begin
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
                if (bus.mem_ready) state_nxt = S_T2;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_nxt  = S_T3;
            end
            S_T3: begin
                if (is_alu || is_md) begin
                    bus.R_out = onehot(is_md ? ra : rb);
                    bus.Yin   = 1'b1;
                    state_nxt = S_T4;
                end else if (op == OP_HALT) begin
                    state_nxt = S_HALT;
                end else begin
                    retire = 1'b1;
                end
            end
            S_T4: begin
                bus.R_out  = onehot(is_md ? rb : rc);
                bus.Zin    = 1'b1;
                bus.OpCode = op;
                state_nxt  = S_T5;
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (is_md) begin
                    bus.LOin  = 1'b1;
                    state_nxt = S_T6;
                end else begin
                    bus.R_in = onehot(ra);
                    retire   = 1'b1;
                end
            end
            S_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                retire       = 1'b1;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase

        if (retire) state_nxt = bus.run ? S_T0 : S_IDLE;
    end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the existing `Datapath` control strobes to fetch and execute instructions, replacing hand-sequenced bench stimulus. It implements a Moore FSM (IDLE, T0–T6, T1W, HALT). The FSM decodes the IR fields for three-register ALU ops, mul/div, and halt. It stalls fetch on a memory-ready handshake and counts retired instructions. It sits beside `Datapath`, takes the IR contents back as `ir`, and its outputs connect one-to-one to the datapath control ports.

## Interface
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- clr  in  1  synchronous active-high reset
- run  in  1  level; 1 = execute, 0 = stop after current instruction
- mem_ready  in  1  memory read data valid on Mdatain this cycle
- ir  in  32  IR register output; opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15]
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus drive strobes
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin  out  1 each  register load strobes
- Read  out  1  memory read enable
- OpCode  out  5  ALU operation select
- R_out  out  16  one-hot GPR bus-drive select
- R_in  out  16  one-hot GPR load select
- halted  out  1  1 while in HALT
- instr_count  out  CNT_W  retired instructions

## Operation
- Outputs are a pure function of the state register, IR fields and `mem_ready`. Any strobe not listed for a state is 0. Out of reset, every output is 0, `OpCode`=0 and `instr_count`=0.
- IDLE: no strobes. Go to T0 when `run`=1.
- T0: PCout, MARin, Zin, OpCode=12 (INC).
- T1: Zlowout, PCin, Read, MDRin. Go to T2 if `mem_ready`, else T1W.
- T1W: Read, MDRin only; PCin is not repeated. Stay until `mem_ready`=1, then go to T2.
- T2: MDRout, IRin.
- T3: decode `ir` (IR loaded at the end of T2).
  - Opcode 0–11 (ALU): R_out[rb], Yin.
  - Opcode 15 (mul) or 16 (div): R_out[ra], Yin.
  - Opcode 27: go to HALT. No strobes this cycle.
  - Any other opcode: no-op. No strobes, go to T0 (or IDLE if `run`=0), and `instr_count` increments.
- T4:
  - ALU: R_out[rc], Zin, OpCode=opcode.
  - mul/div: R_out[rb], Zin, OpCode=opcode.
- T5:
  - ALU: Zlowout, R_in[ra]. Instruction retires.
  - mul/div: Zlowout, LOin, then go to T6.
- T6 (mul/div only): Zhighout, HIin. Instruction retires.
- Retire:
  - `instr_count` increments, wrapping at 2^CNT_W.
  - Next state is T0 if `run`=1, else IDLE.
  - `run` is sampled only at retire and in IDLE; deasserting it mid-instruction never aborts the instruction.
- HALT: `halted`=1, no strobes. Ignores `run` and `mem_ready`; exits only via `clr`. The halt instruction is not counted.
- `clr` has priority over every transition. Asserted in any state, the next state is IDLE, the counter is 0 and all strobes are 0 the next cycle; a pending memory wait is abandoned.
- R_in and R_out are never both non-zero in the same cycle. At most one bit of each is set.

## Timing
- Each T-state lasts exactly one clock, except T1W, which lasts until `mem_ready`.
- Latency with `mem_ready` tied high, measured from T0 entry:
  - ALU op: 6 cycles; result written at the T5 edge.
  - mul/div: 7 cycles.
  - no-op: 4 cycles.
- Each cycle `mem_ready` is low in T1/T1W adds exactly one cycle. Read and MDRin stay high continuously through T1 and all T1W cycles.
- PCin is high for exactly one cycle per instruction, independent of wait cycles.
- `instr_count` updates on the clock edge that leaves the retiring state.
- IDLE→T0 takes one cycle after `run` is sampled high.

## Test plan
- Reset mid-instruction: assert `clr` during T4 of an ALU op. Next cycle: all strobes 0, `R_in`=`R_out`=0, `instr_count`=0, state IDLE. When `run`=1, T0 restarts with PCout=MARin=Zin=1 and OpCode=12.
- ALU op: `ir`=0x28918000 (opcode 5, ra=1, rb=2, rc=3), `mem_ready`=1, `run`=1.
  - T3: R_out=0x0004, Yin=1.
  - T4: R_out=0x0008, OpCode=5, Zin=1.
  - T5: Zlowout=1, R_in=0x0002.
  - Then `instr_count`=1 and the next state is T0.
- Memory wait: hold `mem_ready`=0 for 3 cycles after T1 entry. PCin high exactly 1 cycle; Read/MDRin high 4 consecutive cycles; IRin is asserted the cycle after `mem_ready` rises.
- Mul: `ir`=0x7B380000 (opcode 15, ra=6, rb=7).
  - T3: R_out=0x0040, Yin=1.
  - T4: R_out=0x0080, Zin=1, OpCode=15.
  - T5: LOin=1, Zlowout=1, R_in=0.
  - T6: HIin=1, Zhighout=1.
  - Count increments by 1.
- Stop and halt:
  - Drop `run` during T4: the instruction completes through T5, the next state is IDLE, and the count increments.
  - Then `ir`=0xD8000000 (opcode 27) with `run`=1: `halted`=1 from the cycle after T3. All strobes stay 0 for 20 cycles of `run` toggling, and the count is unchanged.
- Counter wrap: CNT_W=4, 16 back-to-back no-op instructions (opcode 31) → `instr_count` returns to 0. No R_in or R_out bit is ever set during this run.
